// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - UART receiver with frame checking and show-ahead receive FIFO
module uart_rx_buffered #(
    parameter int BAUD_MULT  = 1666,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              i_uart_clk,
    input  logic                              i_rst_n,
    input  logic                              i_rx_data,
    input  logic                              i_rx_ready,
    input  logic                              i_clear_err,
    output logic                              o_rx_active,
    output logic [7:0]                        o_byte_out,
    output logic                              o_data_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count,
    output logic                              o_frame_err,
    output logic                              o_parity_err,
    output logic                              o_overrun
);

    localparam int CNT_W = $clog2(BAUD_MULT + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(BAUD_MULT);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(BAUD_MULT / 2);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             push;
    logic             tick;
    logic             par_xor;
    logic             parity_bad;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             full;
    logic             do_pop;
    logic             do_write;

    // The counter is loaded with a delay in cycles; the sample point is where it reaches 1.
    assign tick       = (bit_cnt <= CNT_W'(1));
    assign par_xor    = ^{shreg, par_bit};
    assign parity_bad = (PARITY == 1) ? ~par_xor :
                        (PARITY == 2) ?  par_xor : 1'b0;

    // Two-flop synchroniser for the asynchronous serial line, idle high.
    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_sync <= rx_meta;
        end
    end

    // Frame receiver: mid-bit sampling, frame/parity checking, push strobe and sticky flags.
    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            push         <= 1'b0;
            o_rx_active  <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            push <= 1'b0;
            if (i_clear_err) begin
                o_frame_err  <= 1'b0;
                o_parity_err <= 1'b0;
            end
            if (state != S_IDLE && state != S_WAIT_HIGH && !tick)
                bit_cnt <= bit_cnt - CNT_W'(1);
            case (state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state       <= S_START;
                        bit_cnt     <= HALF_BIT;
                        shreg       <= '0;
                        o_rx_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_sync) begin
                            state       <= S_IDLE;
                            o_rx_active <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= FULL_BIT;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg[bit_idx] <= rx_sync;
                        bit_cnt        <= FULL_BIT;
                        if (bit_idx == LAST_DATA) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        par_bit <= rx_sync;
                        bit_cnt <= FULL_BIT;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (!rx_sync) begin
                            o_frame_err <= 1'b1;
                            state       <= S_WAIT_HIGH;
                        end else if (stop_idx == STOP_LAST) begin
                            if (parity_bad)
                                o_parity_err <= 1'b1;
                            else
                                push <= 1'b1;
                            state       <= S_IDLE;
                            o_rx_active <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                            bit_cnt  <= FULL_BIT;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state       <= S_IDLE;
                        o_rx_active <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    o_rx_active <= 1'b0;
                end
            endcase
        end
    end

    // A push into a full FIFO is only accepted when the head is popped in the same cycle.
    assign full     = (o_fifo_count == DEPTH_C);
    assign do_pop   = i_rx_ready && o_data_valid;
    assign do_write = push && (!full || do_pop);

    // Next occupancy from the accepted write and pop of this cycle.
    always_comb begin
        count_nxt = o_fifo_count;
        case ({do_write, do_pop})
            2'b10:   count_nxt = o_fifo_count + CW'(1);
            2'b01:   count_nxt = o_fifo_count - CW'(1);
            default: count_nxt = o_fifo_count;
        endcase
    end

    // FIFO storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge i_uart_clk) begin
        if (do_write)
            mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, occupancy, valid flag and overrun flag.
    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
            o_data_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            o_fifo_count <= count_nxt;
            o_data_valid <= (count_nxt != '0);
            if (i_clear_err)
                o_overrun <= 1'b0;
            if (push && full && !do_pop)
                o_overrun <= 1'b1;
        end
    end

    assign o_byte_out = o_data_valid ? mem[rd_ptr] : 8'd0;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - scoreboard bench for uart_rx_buffered (8N1 and 8E1 instances)
module tb_uart_rx_buffered;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic       rdy_a, rdy_b;
    logic       clr;

    logic       act_a, act_b;
    logic [7:0] byte_a, byte_b;
    logic       va, vb;
    logic [2:0] cnt_a, cnt_b;
    logic       fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

    int         checks;
    int         errors;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    uart_rx_buffered #(.BAUD_MULT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .i_uart_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_a), .i_rx_ready(rdy_a), .i_clear_err(clr),
        .o_rx_active(act_a), .o_byte_out(byte_a), .o_data_valid(va), .o_fifo_count(cnt_a),
        .o_frame_err(fe_a), .o_parity_err(pe_a), .o_overrun(ov_a)
    );

    uart_rx_buffered #(.BAUD_MULT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .i_uart_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_b), .i_rx_ready(rdy_b), .i_clear_err(clr),
        .o_rx_active(act_b), .o_byte_out(byte_b), .o_data_valid(vb), .o_fifo_count(cnt_b),
        .o_frame_err(fe_b), .o_parity_err(pe_b), .o_overrun(ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int ch, input logic b);
        if (ch == 0) rx_a = b;
        else         rx_b = b;
        tick_n(4);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        send_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ch, d[i]);
        if (use_par) send_bit(ch, par);
        send_bit(ch, stop);
    endtask

    task automatic pop(input int ch);
        if (ch == 0) rdy_a = 1'b1;
        else         rdy_b = 1'b1;
        tick_n(1);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    // Monitor: every accepted pop is compared with the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (rdy_a && va) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL pop_a unexpected actual=%0h required=none", byte_a);
            end else begin
                exp = q_a.pop_front();
                if (byte_a !== exp) begin
                    errors++;
                    $display("FAIL pop_a byte actual=%0h required=%0h", byte_a, exp);
                end
            end
        end
        if (rdy_b && vb) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL pop_b unexpected actual=%0h required=none", byte_b);
            end else begin
                exp = q_b.pop_front();
                if (byte_b !== exp) begin
                    errors++;
                    $display("FAIL pop_b byte actual=%0h required=%0h", byte_b, exp);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rx_a   = 1'b1;
        rx_b   = 1'b1;
        rdy_a  = 1'b0;
        rdy_b  = 1'b0;
        clr    = 1'b0;
        tick_n(3);
        check("reset_valid", va, 0);
        check("reset_byte", byte_a, 0);
        check("reset_count", cnt_a, 0);
        check("reset_active", act_a, 0);
        check("reset_flags", {fe_a, pe_a, ov_a}, 0);
        rst_n = 1'b1;
        tick_n(4);

        // 8N1 frame 0x41, left in the FIFO
        send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
        q_a.push_back(8'h41);
        tick_n(8);
        check("s1_valid", va, 1);
        check("s1_byte", byte_a, 8'h41);
        check("s1_count", cnt_a, 1);
        check("s1_flags", {fe_a, pe_a, ov_a}, 0);

        // Even parity: 0x41 has two ones, so a parity bit of 1 is wrong
        send_frame(1, 8'h41, 1'b1, 1'b1, 1'b1);
        tick_n(8);
        check("s2_parity_err", pe_b, 1);
        check("s2_count", cnt_b, 0);
        clr = 1'b1;
        tick_n(1);
        clr = 1'b0;
        check("s2_parity_clear", pe_b, 0);
        send_frame(1, 8'h41, 1'b1, 1'b0, 1'b1);
        q_b.push_back(8'h41);
        tick_n(8);
        check("s2_good_count", cnt_b, 1);
        check("s2_good_perr", pe_b, 0);
        pop(1);
        tick_n(2);
        check("s2_empty", vb, 0);

        // 0x55 with a low stop bit, line held low afterwards
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        tick_n(20);
        check("s3_frame_err", fe_a, 1);
        check("s3_active_low", act_a, 1);
        check("s3_count", cnt_a, 1);
        rx_a = 1'b1;
        tick_n(4);
        check("s3_active_high", act_a, 0);
        clr = 1'b1;
        tick_n(1);
        clr = 1'b0;
        check("s3_frame_clear", fe_a, 0);

        // One-cycle glitch low: false start
        rx_a = 1'b0;
        tick_n(1);
        rx_a = 1'b1;
        tick_n(2);
        check("s4_start_seen", act_a, 1);
        tick_n(6);
        check("s4_active", act_a, 0);
        check("s4_flags", {fe_a, pe_a, ov_a}, 0);
        check("s4_count", cnt_a, 1);

        pop(0);
        tick_n(2);
        check("s4_empty_valid", va, 0);
        check("s4_empty_byte", byte_a, 0);

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
            if (i <= 4) q_a.push_back(8'(i));
            tick_n(2);
        end
        tick_n(8);
        check("s5_count", cnt_a, 4);
        check("s5_overrun", ov_a, 1);
        check("s5_head", byte_a, 8'h01);
        for (int i = 0; i < 4; i++) pop(0);
        tick_n(2);
        check("s5_empty", va, 0);
        clr = 1'b1;
        tick_n(1);
        clr = 1'b0;
        check("s5_overrun_clear", ov_a, 0);

        // Reset during data bit 3 of 0xA5, then a clean 0xA5
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        rx_a = 1'b0;
        tick_n(2);
        check("s6_pre_active", act_a, 1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_active", act_a, 0);
        check("s6_rst_valid", va, 0);
        check("s6_rst_byte", byte_a, 0);
        check("s6_rst_count", cnt_a, 0);
        check("s6_rst_flags", {fe_a, pe_a, ov_a}, 0);
        rx_a = 1'b1;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(4);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        q_a.push_back(8'hA5);
        tick_n(8);
        check("s6_count", cnt_a, 1);
        check("s6_head", byte_a, 8'hA5);
        check("s6_flags", {fe_a, pe_a, ov_a}, 0);
        pop(0);
        tick_n(2);
        check("s6_empty", va, 0);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
